// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter that lets two I-caches share one byte-serial block instruction memory.
// Latency: a lone request is granted next cycle, memory runs 16 beats, and busywait releases 18 cycles after the request.
// Backpressure: the non-owner's busywait stays high. The owner is released for one RESP cycle unless it aborted.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_read,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  output logic [DATA_WIDTH-1:0] req0_readdata,
  output logic                  req0_busywait,
  input  logic                  req1_read,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  output logic [DATA_WIDTH-1:0] req1_readdata,
  output logic                  req1_busywait,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait,
  output logic [CNT_WIDTH-1:0]  grant_count0,
  output logic [CNT_WIDTH-1:0]  grant_count1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state, state_next;
  logic                  owner, owner_next;
  logic                  last_owner;
  logic                  abort_q, abort_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt1_q;
  logic                  owner_read;

  // The owner's own read line; used to detect a request withdrawn mid-transaction.
  assign owner_read = owner ? req1_read : req0_read;

  // Next-state, arbitration and memory strobe. Nothing is granted outside IDLE, so RESP always leaves a one-cycle gap.
  always_comb begin
    state_next = state;
    owner_next = owner;
    addr_next  = addr_q;
    abort_next = abort_q;
    mem_read   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_read || req1_read) begin
          // On a tie, the cache that was not served last wins.
          owner_next = (req0_read && req1_read) ? ~last_owner : req1_read;
          addr_next  = owner_next ? req1_address : req0_address;
          abort_next = 1'b0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        mem_read = 1'b1;
        // A withdrawn request still finishes so the memory's beat counter stays aligned.
        if (!owner_read) abort_next = 1'b1;
        if (!mem_busywait) state_next = DRAIN;
      end
      DRAIN:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, grant bookkeeping, response capture and saturating statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      resp_q     <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      abort_q <= abort_next;
      addr_q  <= addr_next;
      if (state == DRAIN) begin
        // The block is complete during DRAIN. Aborted transactions are counted and captured too.
        resp_q     <= mem_readdata;
        last_owner <= owner;
        if (owner) begin
          if (cnt1_q != {CNT_WIDTH{1'b1}}) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
        end else begin
          if (cnt0_q != {CNT_WIDTH{1'b1}}) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign req0_busywait = req0_read & ~((state == RESP) && !owner && !abort_q);
  assign req1_busywait = req1_read & ~((state == RESP) &&  owner && !abort_q);
  assign req0_readdata = resp_q;
  assign req1_readdata = resp_q;
  assign mem_address   = addr_q;
  assign grant_count0  = cnt0_q;
  assign grant_count1  = cnt1_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed-plus-random bench for imem_port_arbiter with a 16-beat byte-serial memory model.
// Each transaction is checked cycle by cycle against a timeline model: grant at c0, GRANT c1-16, DRAIN c17, RESP c18.
// Caches hold read until released; a loser keeps its request asserted until it is served.
module tb_imem_port_arbiter;

  localparam int AW   = 28;
  localparam int DW   = 128;
  // A narrow counter keeps the saturation boundary reachable in a short run.
  localparam int CNTW = 5;
  localparam int MAXC = (1 << CNTW) - 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            req0_read, req1_read;
  logic [AW-1:0]   req0_address, req1_address;
  logic [DW-1:0]   req0_readdata, req1_readdata;
  logic            req0_busywait, req1_busywait;
  logic            mem_read;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_readdata;
  logic            mem_busywait;
  logic [CNTW-1:0] grant_count0, grant_count1;

  int total = 0;
  int bad   = 0;
  int last_m = 1;
  int cnt_m [2];

  logic [7:0] mem_bytes [256];
  logic [3:0] beat;

  imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) dut (
    .clock(clock), .reset(reset),
    .req0_read(req0_read), .req0_address(req0_address),
    .req0_readdata(req0_readdata), .req0_busywait(req0_busywait),
    .req1_read(req1_read), .req1_address(req1_address),
    .req1_readdata(req1_readdata), .req1_busywait(req1_busywait),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .grant_count0(grant_count0), .grant_count1(grant_count1)
  );

  always #5 clock = ~clock;

  // Byte-serial memory: one byte per cycle while read is high, last beat signalled by busywait low.
  always @(posedge clock) begin
    if (reset) begin
      beat <= 4'd0;
    end else if (mem_read) begin
      mem_readdata[beat*8 +: 8] <= mem_bytes[{mem_address[3:0], beat}];
      beat <= beat + 4'd1;
    end
  end
  assign mem_busywait = !(mem_read && beat == 4'd15);

  function automatic logic [DW-1:0] exp_block(input logic [AW-1:0] a);
    logic [DW-1:0] blk;
    logic [7:0]    idx;
    blk = '0;
    for (int i = 0; i < 16; i++) begin
      idx = {a[3:0], i[3:0]};
      blk[i*8 +: 8] = mem_bytes[idx];
    end
    return blk;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_read(input int p, input logic v);
    if (p == 1) req1_read = v; else req0_read = v;
  endtask

  // Runs one arbitrated transaction starting in an IDLE cycle (c0) and returns at the start of c19.
  // drop_at: cycle in which the winner withdraws its read (0 = never); reraise: winner requests again in DRAIN.
  task automatic transact(input int drop_at, input bit reraise);
    int            w, ecnt;
    logic [AW-1:0] wa;
    logic [DW-1:0] blk;
    bit            ab;
    logic          wr, lr;
    if (req0_read && req1_read) w = 1 - last_m;
    else if (req0_read)         w = 0;
    else                        w = 1;
    wa   = (w == 1) ? req1_address : req0_address;
    blk  = exp_block(wa);
    ab   = (drop_at >= 1 && drop_at <= 16);
    ecnt = (cnt_m[w] >= MAXC) ? MAXC : cnt_m[w] + 1;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clock);
      wr = (w == 1) ? req1_read : req0_read;
      lr = (w == 1) ? req0_read : req1_read;
      chk("mem_read", mem_read, (c >= 1 && c <= 16));
      if (c >= 1 && c <= 16) chk("mem_address", mem_address, wa);
      chk((w == 1) ? "owner_busy1" : "owner_busy0",
          (w == 1) ? req1_busywait : req0_busywait, wr && !(c == 18 && !ab));
      chk((w == 1) ? "other_busy0" : "other_busy1",
          (w == 1) ? req0_busywait : req1_busywait, lr);
      if (c == 18) begin
        chk("readdata0", req0_readdata, blk);
        chk("readdata1", req1_readdata, blk);
        chk("grant_count0", grant_count0, (w == 0) ? ecnt : cnt_m[0]);
        chk("grant_count1", grant_count1, (w == 1) ? ecnt : cnt_m[1]);
      end
      @(posedge clock); #1;
      if (c + 1 == drop_at) set_read(w, 1'b0);
      if (reraise && c + 1 == 17) begin
        set_read(w, 1'b1);
        if (w == 1) req1_address = AW'($urandom); else req0_address = AW'($urandom);
      end
      if (c + 1 == 19 && !reraise) set_read(w, 1'b0);
    end
    last_m   = w;
    cnt_m[w] = ecnt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
    cnt_m[0] = 0; cnt_m[1] = 0;
    reset = 1'b1;
    req0_read = 1'b0; req1_read = 1'b0;
    req0_address = '0; req1_address = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("idle_mem_read", mem_read, 1'b0);
      chk("idle_mem_address", mem_address, '0);
      chk("idle_busy0", req0_busywait, 1'b0);
      chk("idle_busy1", req1_busywait, 1'b0);
      chk("idle_count0", grant_count0, '0);
      chk("idle_count1", grant_count1, '0);
      chk("idle_readdata0", req0_readdata, '0);
      chk("idle_readdata1", req1_readdata, '0);
      @(posedge clock); #1;
    end

    // Lone cache-0 read of block 1 (bytes 16..31).
    req0_address = 28'h0000001; req0_read = 1'b1;
    transact(0, 1'b0);

    // Cache 1 withdraws in GRANT cycle 5; the transaction still completes without a release.
    req1_address = AW'($urandom); req1_read = 1'b1;
    transact(5, 1'b0);

    // Both caches keep requesting: grants must alternate 0,1,0,1.
    req0_address = AW'($urandom); req1_address = AW'($urandom);
    req0_read = 1'b1; req1_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_order_pre", last_m, (k % 2 == 0) ? 1 : 0);
      transact(0, 1'b0);
      chk("rr_order", last_m, k % 2);
      if (k < 3) set_read(last_m, 1'b1);
    end
    transact(0, 1'b0);

    // Reset in GRANT cycle 8 while cache 0 keeps requesting.
    req0_address = AW'($urandom); req0_read = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) reset = 1'b1;
      @(negedge clock);
      chk("pre_reset_mem_read", mem_read, (c >= 1));
      chk("pre_reset_busy0", req0_busywait, 1'b1);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    last_m = 1; cnt_m[0] = 0; cnt_m[1] = 0;
    transact(0, 1'b0);

    // Withdraw then re-request in DRAIN: aborted RESP keeps busywait high.
    req1_address = AW'($urandom); req1_read = 1'b1;
    transact(9, 1'b1);
    transact(0, 1'b0);

    // Randomized traffic; pending requests stay asserted until served.
    for (int k = 0; k < 20; k++) begin
      int d;
      bit rr;
      if (!req0_read && ($urandom % 2 == 0)) begin req0_read = 1'b1; req0_address = AW'($urandom); end
      if (!req1_read && ($urandom % 2 == 0)) begin req1_read = 1'b1; req1_address = AW'($urandom); end
      if (!req0_read && !req1_read) begin req0_read = 1'b1; req0_address = AW'($urandom); end
      d  = ($urandom % 3 == 0) ? int'($urandom_range(1, 16)) : 0;
      rr = (d != 0) && ($urandom % 2 == 0);
      transact(d, rr);
    end
    for (int k = 0; k < 4 && (req0_read || req1_read); k++) transact(0, 1'b0);

    // Saturation of the cache-0 counter.
    for (int k = 0; k < MAXC + 2; k++) begin
      req0_address = AW'($urandom); req0_read = 1'b1;
      transact(0, 1'b0);
    end
    @(negedge clock);
    chk("count0_saturated", grant_count0, {CNTW{1'b1}});
    chk("final_mem_read", mem_read, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
